// File: rtl/seg7_rx.sv
// seg7_rx: seven-segment loopback receiver.
// Debounces, decodes and sequence-checks a segment pattern.
module seg7_rx #(
  parameter int STABLE_CYCLES = 16,
  parameter int WRAP_DIGIT    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       clr_err,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       new_digit,
  output logic       bad_pattern,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0] WRAP    = 4'(WRAP_DIGIT);

  logic [6:0] sync1;
  logic [6:0] sync2;
  logic [6:0] cand;
  logic [6:0] acc;
  logic [7:0] cnt;

  logic       stable;
  logic       accept;
  logic       is_blank;
  logic       dec_ok;
  logic [3:0] dec_val;
  logic [3:0] exp_val;
  logic       seq_bad;
  logic       err_evt;

  // two-flop synchronizer on the asynchronous pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 7'h00;
      sync2 <= 7'h00;
    end else begin
      sync1 <= seg_in;
      sync2 <= sync1;
    end
  end

  // candidate tracking with a saturating hold counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand <= 7'h00;
      cnt  <= 8'd0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= 8'd0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign stable   = (sync2 == cand) && (cnt == CNT_MAX);
  assign accept   = stable && (cand != acc);
  assign is_blank = (cand == 7'h00);

  // active-high segment decode, a=bit0 .. g=bit6
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    unique case (cand)
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  // next digit the driver should show after the current one
  always_comb begin
    if (digit == WRAP) exp_val = 4'd0;
    else               exp_val = digit + 4'd1;
  end

  assign seq_bad = dec_ok && !is_blank && locked
                 && (dec_val != exp_val);
  assign err_evt = accept
                 && ((!dec_ok && !is_blank) || seq_bad);

  // accept handling and registered status/pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= 7'h00;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      new_digit   <= 1'b0;
      bad_pattern <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      new_digit   <= 1'b0;
      bad_pattern <= 1'b0;
      seq_err     <= 1'b0;
      if (accept) begin
        acc <= cand;
        if (is_blank) begin
          digit_valid <= 1'b0;
          locked      <= 1'b0;
        end else if (!dec_ok) begin
          bad_pattern <= 1'b1;
          digit_valid <= 1'b0;
          locked      <= 1'b0;
        end else begin
          digit       <= dec_val;
          digit_valid <= 1'b1;
          new_digit   <= 1'b1;
          seq_err     <= seq_bad;
          locked      <= 1'b1;
        end
      end
    end
  end

  // saturating error counter; a clear wins but keeps a same-cycle error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (clr_err) begin
      err_count <= err_evt ? 8'd1 : 8'd0;
    end else if (err_evt && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_seg7_rx.sv
// tb_seg7_rx: table vectors, corner sequences and
// randomized patterns against a run-length reference model.
module tb_seg7_rx;

  localparam int SC = 16;
  localparam int WD = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic       clr_err = 1'b0;
  logic [3:0] digit;
  logic       digit_valid;
  logic       new_digit;
  logic       bad_pattern;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  seg7_rx #(.STABLE_CYCLES(SC), .WRAP_DIGIT(WD)) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .clr_err(clr_err),
    .digit(digit),
    .digit_valid(digit_valid),
    .new_digit(new_digit),
    .bad_pattern(bad_pattern),
    .seq_err(seq_err),
    .locked(locked),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: a pattern is accepted once the pin samples,
  // seen two clocks late, have held one value for SC+1 clocks
  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] q [$];
  logic [6:0] rv;
  logic [6:0] m_acc;
  int rl;
  int m_digit, m_err;
  bit m_valid, m_new, m_bad, m_seq, m_locked;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      rv = 7'h00; rl = 1; m_acc = 7'h00;
      m_digit = 0; m_err = 0;
      m_valid = 0; m_new = 0; m_bad = 0; m_seq = 0; m_locked = 0;
    end else begin
      logic [6:0] d;
      int v;
      bit evt;
      q.push_back(seg_in);
      d = (q.size() > 2) ? q.pop_front() : 7'h00;
      if (d == rv) begin
        if (rl < 1000) rl++;
      end else begin
        rv = d;
        rl = 1;
      end
      m_new = 0; m_bad = 0; m_seq = 0; evt = 0;
      if (rl >= SC + 1 && rv != m_acc) begin
        m_acc = rv;
        v = -1;
        for (int i = 0; i < 10; i++) if (pats[i] == rv) v = i;
        if (rv == 7'h00) begin
          m_valid = 0; m_locked = 0;
        end else if (v < 0) begin
          m_bad = 1; evt = 1; m_valid = 0; m_locked = 0;
        end else begin
          m_new = 1;
          if (m_locked && v != ((m_digit == WD) ? 0 : m_digit + 1)) begin
            m_seq = 1; evt = 1;
          end
          m_digit = v; m_valid = 1; m_locked = 1;
        end
      end
      if (clr_err) m_err = evt ? 1 : 0;
      else if (evt && m_err < 255) m_err++;
    end
  end

  // every cycle, all outputs against the model
  always @(negedge clk) begin
    chk("model_digit", int'(digit), m_digit);
    chk("model_flags",
        int'({digit_valid, new_digit, bad_pattern, seq_err, locked}),
        int'({m_valid, m_new, m_bad, m_seq, m_locked}));
    chk("model_err", int'(err_count), m_err);
  end

  typedef struct {
    logic [6:0] seg;
    int dig, val, lck, nd, bad, seq, err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int nd, bs, ss;
    tbl[0]  = '{7'h06, 1, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{7'h5B, 2, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{7'h4F, 3, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{7'h66, 4, 1, 1, 1, 0, 0, 0};
    tbl[4]  = '{7'h6D, 5, 1, 1, 1, 0, 0, 0};
    tbl[5]  = '{7'h7D, 6, 1, 1, 1, 0, 0, 0};
    tbl[6]  = '{7'h07, 7, 1, 1, 1, 0, 0, 0};
    tbl[7]  = '{7'h3F, 0, 1, 1, 1, 0, 0, 0};
    tbl[8]  = '{7'h06, 1, 1, 1, 1, 0, 0, 0};
    tbl[9]  = '{7'h5B, 2, 1, 1, 1, 0, 0, 0};
    tbl[10] = '{7'h66, 4, 1, 1, 1, 0, 1, 1};
    tbl[11] = '{7'h6D, 5, 1, 1, 1, 0, 0, 1};
    tbl[12] = '{7'h55, 5, 0, 0, 0, 1, 0, 2};
    tbl[13] = '{7'h00, 5, 0, 0, 0, 0, 0, 2};
    tbl[14] = '{7'h7F, 8, 1, 1, 1, 0, 0, 2};
    tbl[15] = '{7'h6F, 9, 1, 1, 1, 0, 0, 2};
    tbl[16] = '{7'h3F, 0, 1, 1, 1, 0, 1, 3};

    repeat (3) @(negedge clk);
    chk("reset_state",
        int'({digit, digit_valid, new_digit, bad_pattern,
              seq_err, locked, err_count}), 0);

    // first accept latency
    @(negedge clk);
    reset = 1'b0;
    seg_in = 7'h3F;
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("edge18_no_accept", int'(new_digit), 0);
    @(negedge clk);
    chk("edge19_new_digit", int'(new_digit), 1);
    chk("edge19_digit", int'(digit), 0);
    chk("edge19_valid", int'(digit_valid), 1);
    chk("edge19_locked", int'(locked), 1);
    chk("edge19_err", int'(err_count), 0);
    repeat (10) @(negedge clk);

    // table of held patterns
    for (int i = 0; i < 17; i++) begin
      seg_in = tbl[i].seg;
      nd = 0; bs = 0; ss = 0;
      repeat (25) begin
        @(negedge clk);
        nd += int'(new_digit);
        bs |= int'(bad_pattern);
        ss |= int'(seq_err);
      end
      chk($sformatf("tbl%0d_digit", i), int'(digit), tbl[i].dig);
      chk($sformatf("tbl%0d_valid", i), int'(digit_valid), tbl[i].val);
      chk($sformatf("tbl%0d_locked", i), int'(locked), tbl[i].lck);
      chk($sformatf("tbl%0d_new", i), nd, tbl[i].nd);
      chk($sformatf("tbl%0d_bad", i), bs, tbl[i].bad);
      chk($sformatf("tbl%0d_seq", i), ss, tbl[i].seq);
      chk($sformatf("tbl%0d_err", i), int'(err_count), tbl[i].err);
    end

    // bouncing input never settles long enough
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      seg_in = (i % 2 == 1) ? 7'h06 : 7'h5B;
      repeat (10) begin
        @(negedge clk);
        nd += int'(new_digit);
      end
    end
    chk("bounce_no_accept", nd, 0);
    seg_in = 7'h5B;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      nd += int'(new_digit);
    end
    chk("settle_one_accept", nd, 1);
    chk("settle_digit", int'(digit), 2);

    // randomized patterns and clears, checked by the model
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6) seg_in = pats[$urandom_range(0, 9)];
      else if (sel < 8) seg_in = 7'h00;
      else seg_in = 7'($urandom);
      repeat ($urandom_range(1, 30)) begin
        clr_err = ($urandom_range(0, 19) == 0);
        @(negedge clk);
      end
    end
    clr_err = 1'b0;

    // error flood saturates the counter
    for (int i = 0; i < 300; i++) begin
      seg_in = (i % 2 == 1) ? 7'h2A : 7'h55;
      repeat (20) @(negedge clk);
    end
    chk("err_saturate", int'(err_count), 255);

    // clear coinciding with an error leaves one
    seg_in = 7'h41;
    repeat (18) @(posedge clk);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_with_err_bad", int'(bad_pattern), 1);
    chk("clr_with_err_count", int'(err_count), 1);
    repeat (5) @(negedge clk);

    // reset in the middle of a stability count
    seg_in = 7'h06;
    repeat (13) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_clear",
        int'({digit, digit_valid, new_digit, bad_pattern,
              seq_err, locked, err_count}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("post_reset_edge18", int'(new_digit), 0);
    @(negedge clk);
    chk("post_reset_new", int'(new_digit), 1);
    chk("post_reset_digit", int'(digit), 1);
    chk("post_reset_seq", int'(seq_err), 0);
    chk("post_reset_valid", int'(digit_valid), 1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_rx.md
Name: seg7_rx

Overview:
- Receive side of the seven-segment display path: samples a 7-bit segment pattern from input pins and decodes it back to a digit.
- Debounces the pattern, flags illegal patterns, and checks that successive digits follow the up-counting sequence the display driver produces.
- Used as an on-chip loopback checker and for board-level self-test.

Parameters:
STABLE_CYCLES, 16, consecutive cycles a synchronized pattern must hold before acceptance; legal range 2..255
WRAP_DIGIT, 7, last digit of the expected sequence; after WRAP_DIGIT the expected next digit is 0; legal range 1..9

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
seg_in  input  7  segment pattern, bit0=a … bit6=g, active high, asynchronous to clk
clr_err  input  1  synchronous pulse; clears err_count
digit  output  4  last accepted digit value, 0..9
digit_valid  output  1  high while digit holds a valid decoded value
new_digit  output  1  one-cycle pulse when a new valid digit is accepted
bad_pattern  output  1  one-cycle pulse when an illegal pattern is accepted
seq_err  output  1  one-cycle pulse when an accepted digit breaks the sequence
locked  output  1  high once a valid digit has been accepted and no illegal/blank pattern has followed
err_count  output  8  saturating count of bad_pattern and seq_err events

Behaviour:
- Reset is asynchronous and active-high on port reset, single clock clk.
- Reset values:
  - digit=0, digit_valid=0, new_digit=0, bad_pattern=0, seq_err=0, locked=0, err_count=0.
  - Synchronizer flops, candidate register and accepted register = 7'h00.
  - Stability counter = 0.
- Synchronizer: 2-flop on all 7 bits (sync1 → sync2).
- Stability tracking, per edge:
  - If sync2 ≠ cand: cand<=sync2, cnt<=0.
  - Else, if cnt < STABLE_CYCLES-1: cnt<=cnt+1.
- Accept event: sync2==cand, cnt==STABLE_CYCLES-1, and cand ≠ acc. On that edge acc<=cand and all outputs update. At most one accept per stable pattern; re-accepting an unchanged pattern is impossible.
- Latency: a pattern first sampled by sync1 at edge 1 produces the accept-event outputs after edge STABLE_CYCLES+3 (19 with default), provided seg_in holds stable throughout. Any change restarts the count.
- Decode table, active-high; every other nonzero pattern is illegal:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9
- Accept of a legal digit v:
  - digit<=v, digit_valid<=1, new_digit pulses.
  - If locked=1 and v ≠ expected, seq_err pulses. Expected = prev+1, or 0 when prev==WRAP_DIGIT. The checker resyncs: the next expected value is computed from v.
  - locked<=1.
- Accept of 7'h00 (blank): digit_valid<=0, locked<=0, no pulses, no error; digit holds its old value.
- Accept of an illegal pattern: bad_pattern pulses, digit_valid<=0, locked<=0, digit holds.
- Pulses are exactly one cycle. bad_pattern and seq_err are mutually exclusive.
- err_count:
  - +1 on each bad_pattern or seq_err.
  - Saturates at 255.
  - clr_err sets it to 0.
  - If clr_err coincides with an error event, err_count becomes 1.
- Digits outside 0..WRAP_DIGIT are legal patterns. They raise seq_err only when they break the expected sequence.
- Reset asserted mid-stability-count or mid-pulse clears everything immediately. No pulse is emitted on reset release.
- All outputs are registered; no combinational path from seg_in to outputs.

Test Plan:
- Reset, then drive seg_in=7'h3F held 30 cycles → new_digit pulse after edge 19, digit=0, digit_valid=1, locked=1, err_count=0.
- Drive sequence 3F,06,5B,4F,66,6D,7D,07,3F, each held 25 cycles → nine new_digit pulses, digits 0..7,0, seq_err never asserted.
- With locked at digit 2 (5B), drive 66 (4) → seq_err one-cycle pulse, err_count=1. Then drive 6D (5) → no seq_err, since resync expected 5.
- Toggle seg_in between 06 and 5B every 10 cycles for 200 cycles → no accept event, new_digit stays 0. Then hold 5B for 20 cycles → single accept, digit=2.
- Drive illegal 7'h55 → bad_pattern pulse, digit_valid=0, locked=0, err_count +1. Force 300 errors → err_count=255. Assert clr_err together with an error → err_count=1.
- Assert reset at cnt=10 while 7'h06 is settling → all outputs 0 immediately. After release, 7'h06 held → accepted 19 edges after release with digit=1 and no seq_err.
